hazard_tracker: RTL and testbench

Pipeline hazard unit for the five-stage RV32I core. It consumes the per-instruction hazard and decode signals produced by the ID-stage control decoder. It keeps a registered scoreboard of the instructions in EX, MEM and WB, and from that drives stall, flush and ID-stage forwarding selects. It also keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_tracker.sv | 245 ++++++++++++++++++++++++
 tb/tb_hazard_tracker.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// -----------------------------------------------------------------------------
// hazard_tracker
//
// Hazard unit for the five-stage RV32I core. It tracks what sits in EX, MEM
// and WB in a small registered scoreboard. From that scoreboard and the
// instruction currently in ID it produces, combinationally:
//   - load-use stalls,
//   - branch flushes,
//   - ID-stage operand forwarding selects,
//   - the store-data fix-up select for a store sitting in MEM.
// Saturating stall/flush event counters are kept for debug.
// -----------------------------------------------------------------------------
module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             rs1use,
    input  logic             rs2use,
    input  logic [1:0]       hazard_optype,
    input  logic             RegWrite,
    input  logic             DatatoReg,
    input  logic             mem_w,
    input  logic             Branch,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // hazard_optype value marking rs2 as store data (exempt from load-use stall)
    localparam logic [1:0] OPT_STORE   = 2'b10;

    // ID operand source encodings
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    // EX and MEM carry everything needed downstream; WB only needs what the
    // store-data fix-up looks at.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic       store;
        logic [4:0] rs2;
    } pipe_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } wb_slot_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    pipe_slot_t       r_ex;
    pipe_slot_t       r_mem;
    wb_slot_t         r_wb;
    logic             r_out_en;      // low in reset and for the first cycle after
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    pipe_slot_t       w_id_slot;
    logic             w_ex_hit_rs1;
    logic             w_ex_hit_rs2;
    logic             w_mem_hit_rs1;
    logic             w_mem_hit_rs2;
    logic             w_lu_rs1;
    logic             w_lu_rs2;
    logic             w_stall_raw;
    logic             w_stall;
    logic             w_flush;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_fwd_ls;

    // A slot produces register r only if it is a real, writing instruction
    // with a non-zero destination equal to r. x0 never matches.
    function automatic logic f_match(input logic       valid,
                                     input logic       wr,
                                     input logic [4:0] rd,
                                     input logic [4:0] r);
        return valid & wr & (rd != 5'd0) & (rd == r);
    endfunction

    // Operand source priority: EX ALU result first; an EX load match stays on
    // the register file because the stall (or, for store data, the later
    // WB->MEM fix-up) covers it; then MEM, choosing load data or ALU result.
    function automatic logic [1:0] f_fwd_sel(input logic use_op,
                                             input logic ex_hit,
                                             input logic ex_load,
                                             input logic mem_hit,
                                             input logic mem_load);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_op) begin
            if (ex_hit && !ex_load) begin
                sel = FWD_EX_ALU;
            end else if (ex_hit) begin
                sel = FWD_RF;
            end else if (mem_hit) begin
                sel = mem_load ? FWD_MEM_LD : FWD_MEM_ALU;
            end
        end
        return sel;
    endfunction

    // Pack the ID-stage decode into the slot format entering EX
    always_comb begin
        w_id_slot       = '0;
        w_id_slot.valid = id_valid;
        w_id_slot.rd    = id_rd;
        w_id_slot.wr    = RegWrite;
        w_id_slot.load  = DatatoReg;
        w_id_slot.store = mem_w;
        w_id_slot.rs2   = id_rs2;
    end

    // Register matches of the ID source operands against EX and MEM
    always_comb begin
        w_ex_hit_rs1  = f_match(r_ex.valid,  r_ex.wr,  r_ex.rd,  id_rs1);
        w_ex_hit_rs2  = f_match(r_ex.valid,  r_ex.wr,  r_ex.rd,  id_rs2);
        w_mem_hit_rs1 = f_match(r_mem.valid, r_mem.wr, r_mem.rd, id_rs1);
        w_mem_hit_rs2 = f_match(r_mem.valid, r_mem.wr, r_mem.rd, id_rs2);
    end

    // Load-use stall and branch flush; a stall masks the branch because its
    // operands are stale this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here up front); a missed path would infer a latch.
        w_lu_rs1    = 1'b0;
        w_lu_rs2    = 1'b0;
        w_stall_raw = 1'b0;
        w_stall     = 1'b0;
        w_flush     = 1'b0;

        w_lu_rs1    = id_valid & rs1use & w_ex_hit_rs1 & r_ex.load;
        w_lu_rs2    = id_valid & rs2use & w_ex_hit_rs2 & r_ex.load
                    & (hazard_optype != OPT_STORE);
        w_stall_raw = w_lu_rs1 | w_lu_rs2;

        w_stall     = r_out_en & w_stall_raw;
        w_flush     = r_out_en & Branch & id_valid & ~w_stall_raw;
    end

    // Forwarding selects for the ID operands and the MEM store-data fix-up
    always_comb begin
        w_fwd_a  = FWD_RF;
        w_fwd_b  = FWD_RF;
        w_fwd_ls = 1'b0;

        if (r_out_en) begin
            w_fwd_a  = f_fwd_sel(rs1use, w_ex_hit_rs1, r_ex.load,
                                 w_mem_hit_rs1, r_mem.load);
            // An exempt store-data match on an EX load lands in the
            // ex_hit & ex_load branch and stays on the register file.
            w_fwd_b  = f_fwd_sel(rs2use, w_ex_hit_rs2, r_ex.load,
                                 w_mem_hit_rs2, r_mem.load);
            w_fwd_ls = r_mem.valid & r_mem.store
                     & f_match(r_wb.valid, r_wb.wr, r_wb.rd, r_mem.rs2)
                     & r_wb.load;
        end
    end

    // Output enable: holds all outputs at zero through reset and the first
    // cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    // Scoreboard shift: a stall injects a bubble into EX, MEM/WB always advance
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the scoreboard is a handful of flops, not a RAM, and its valid
        // bits gate every hazard decision, so all slots are reset explicitly.
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            if (w_stall) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id_slot;
            end
            r_mem      <= r_ex;
            r_wb.valid <= r_mem.valid;
            r_wb.rd    <= r_mem.rd;
            r_wb.wr    <= r_mem.wr;
            r_wb.load  <= r_mem.load;
        end
    end

    // Saturating debug event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign stall_PC        = w_stall;
    assign stall_IFID      = w_stall;
    assign flush_IDEX      = w_stall;
    assign flush_IFID      = w_flush;
    assign forward_ctrl_A  = w_fwd_a;
    assign forward_ctrl_B  = w_fwd_b;
    assign forward_ctrl_ls = w_fwd_ls;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_hazard_tracker
//
// Drives ID-stage instructions (directed test-plan sequences, an asynchronous
// reset in the middle of a stall, then random traffic). A reference model
// keeps the in-flight instructions as a 3-deep queue (EX, MEM, WB) and
// derives the expected outputs from the hazard rules; each cycle's
// expectation is queued and a separate monitor compares it against the DUT
// on the falling edge. A second instance with 3-bit counters exercises
// counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_tracker;

    localparam int BIG_MAX   = 65535;
    localparam int SMALL_W   = 3;
    localparam int SMALL_MAX = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        rs1use, rs2use;
    logic [1:0]  hazard_optype;
    logic        RegWrite, DatatoReg, mem_w, Branch;

    logic        stall_PC, stall_IFID, flush_IFID, flush_IDEX;
    logic [1:0]  forward_ctrl_A, forward_ctrl_B;
    logic        forward_ctrl_ls;
    logic [15:0] stall_cnt, flush_cnt;

    logic              s_stall_PC, s_stall_IFID, s_flush_IFID, s_flush_IDEX;
    logic [1:0]        s_fwd_a, s_fwd_b;
    logic              s_fwd_ls;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_tracker #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .rs1use(rs1use), .rs2use(rs2use), .hazard_optype(hazard_optype),
        .RegWrite(RegWrite), .DatatoReg(DatatoReg), .mem_w(mem_w), .Branch(Branch),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_tracker #(.CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .rs1use(rs1use), .rs2use(rs2use), .hazard_optype(hazard_optype),
        .RegWrite(RegWrite), .DatatoReg(DatatoReg), .mem_w(mem_w), .Branch(Branch),
        .stall_PC(s_stall_PC), .stall_IFID(s_stall_IFID),
        .flush_IFID(s_flush_IFID), .flush_IDEX(s_flush_IDEX),
        .forward_ctrl_A(s_fwd_a), .forward_ctrl_B(s_fwd_b),
        .forward_ctrl_ls(s_fwd_ls),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        bit       valid;
        bit [4:0] rs1, rs2, rd;
        bit       rs1use, rs2use;
        bit [1:0] optype;
        bit       wr, load, store, branch;
    } id_t;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr, load, store;
        bit [4:0] rs2;
    } slot_t;

    typedef struct {
        bit       stall, flush;
        bit [1:0] fa, fb;
        bit       ls;
        int       scnt, fcnt;
    } exp_t;

    slot_t pipe[$];          // [0] = EX, [1] = MEM, [2] = WB
    bit    model_en;
    int    m_scnt, m_fcnt;
    id_t   cur_id;
    exp_t  cur_exp;
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    function automatic bit produces(slot_t s, bit [4:0] r);
        return s.valid && s.wr && (r != 0) && (s.rd == r);
    endfunction

    function automatic bit [1:0] source(bit used, bit [4:0] r, slot_t ex, slot_t mem);
        if (!used) return 2'd0;
        if (produces(ex, r)) return ex.load ? 2'd0 : 2'd1;
        if (produces(mem, r)) return mem.load ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t predict(id_t id);
        exp_t  e;
        slot_t ex, mem, wb;
        e = '{default: 0};
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        if (!model_en) return e;
        ex  = pipe[0];
        mem = pipe[1];
        wb  = pipe[2];
        e.stall = id.valid && ex.load &&
                  ((id.rs1use && produces(ex, id.rs1)) ||
                   (id.rs2use && produces(ex, id.rs2) && id.optype != 2'b10));
        e.flush = id.branch && id.valid && !e.stall;
        e.fa    = source(id.rs1use, id.rs1, ex, mem);
        e.fb    = source(id.rs2use, id.rs2, ex, mem);
        e.ls    = mem.valid && mem.store && wb.load && produces(wb, mem.rs2);
        return e;
    endfunction

    task automatic model_reset();
        slot_t b;
        b = '{default: 0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
        model_en = 0;
        m_scnt   = 0;
        m_fcnt   = 0;
    endtask

    // Clock edge: the instruction in ID enters the pipe unless it stalled
    task automatic model_step();
        slot_t s;
        s = '{default: 0};
        if (!cur_exp.stall) begin
            s.valid = cur_id.valid;
            s.rd    = cur_id.rd;
            s.wr    = cur_id.wr;
            s.load  = cur_id.load;
            s.store = cur_id.store;
            s.rs2   = cur_id.rs2;
        end
        pipe.push_front(s);
        void'(pipe.pop_back());
        if (cur_exp.stall && m_scnt < BIG_MAX) m_scnt++;
        if (cur_exp.flush && m_fcnt < BIG_MAX) m_fcnt++;
        model_en = 1;
    endtask

    // ------------------------------------------------------------- stimulus
    function automatic id_t nop();
        id_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic id_t alu(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2, bit use2);
        id_t r;
        r = nop();
        r.valid = 1; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.rs1use = 1; r.rs2use = use2; r.optype = 2'b01; r.wr = 1;
        return r;
    endfunction

    function automatic id_t ld(bit [4:0] rd, bit [4:0] rs1);
        id_t r;
        r = nop();
        r.valid = 1; r.rd = rd; r.rs1 = rs1; r.rs1use = 1;
        r.optype = 2'b01; r.wr = 1; r.load = 1;
        return r;
    endfunction

    function automatic id_t st(bit [4:0] rs1, bit [4:0] rs2);
        id_t r;
        r = nop();
        r.valid = 1; r.rs1 = rs1; r.rs2 = rs2; r.rs1use = 1; r.rs2use = 1;
        r.optype = 2'b10; r.store = 1;
        return r;
    endfunction

    function automatic id_t br(bit [4:0] rs1, bit [4:0] rs2, bit taken);
        id_t r;
        r = nop();
        r.valid = 1; r.rs1 = rs1; r.rs2 = rs2; r.rs1use = 1; r.rs2use = 1;
        r.optype = 2'b01; r.branch = taken;
        return r;
    endfunction

    function automatic id_t rnd_id();
        id_t r;
        bit [4:0] a, b, d;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0:       r = nop();
            1, 2, 3: r = alu(d, a, b, 1'($urandom));
            4, 5:    r = ld(d, a);
            6, 7:    r = st(a, b);
            8:       r = br(a, b, 1'($urandom));
            default: begin
                r.valid = 1'($urandom); r.rs1 = a; r.rs2 = b; r.rd = d;
                r.rs1use = 1'($urandom); r.rs2use = 1'($urandom);
                r.optype = 2'($urandom); r.wr = 1'($urandom);
                r.load = 1'($urandom); r.store = 1'($urandom);
                r.branch = 1'($urandom);
            end
        endcase
        return r;
    endfunction

    task automatic drive(id_t id);
        id_valid = id.valid; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        rs1use = id.rs1use; rs2use = id.rs2use; hazard_optype = id.optype;
        RegWrite = id.wr; DatatoReg = id.load; mem_w = id.store; Branch = id.branch;
    endtask

    task automatic present(id_t id);
        cur_id = id;
        drive(id);
        cur_exp = predict(id);
        exp_q.push_back(cur_exp);
    endtask

    task automatic tick(id_t id);
        @(posedge clk);
        model_step();
        #1;
        present(id);
    endtask

    // Issue one instruction, holding it in ID for as long as it stalls
    task automatic issue(id_t id);
        tick(id);
        for (int k = 0; k < 3 && cur_exp.stall; k++) tick(id);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_PC"},   stall_PC, 0);
        check({tag, "_stall_IFID"}, stall_IFID, 0);
        check({tag, "_flush_IDEX"}, flush_IDEX, 0);
        check({tag, "_flush_IFID"}, flush_IFID, 0);
        check({tag, "_fwd_A"},      forward_ctrl_A, 0);
        check({tag, "_fwd_B"},      forward_ctrl_B, 0);
        check({tag, "_fwd_ls"},     forward_ctrl_ls, 0);
        check({tag, "_stall_cnt"},  stall_cnt, 0);
        check({tag, "_flush_cnt"},  flush_cnt, 0);
        check({tag, "_small_stall_cnt"}, s_stall_cnt, 0);
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        exp_t e;
        int   sm_s, sm_f;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                sm_s = (e.scnt > SMALL_MAX) ? SMALL_MAX : e.scnt;
                sm_f = (e.fcnt > SMALL_MAX) ? SMALL_MAX : e.fcnt;
                check("stall_PC",        stall_PC,        e.stall);
                check("stall_IFID",      stall_IFID,      e.stall);
                check("flush_IDEX",      flush_IDEX,      e.stall);
                check("flush_IFID",      flush_IFID,      e.flush);
                check("forward_ctrl_A",  forward_ctrl_A,  e.fa);
                check("forward_ctrl_B",  forward_ctrl_B,  e.fb);
                check("forward_ctrl_ls", forward_ctrl_ls, e.ls);
                check("stall_cnt",       stall_cnt,       e.scnt);
                check("flush_cnt",       flush_cnt,       e.fcnt);
                check("small_stall_cnt", s_stall_cnt,     sm_s);
                check("small_flush_cnt", s_flush_cnt,     sm_f);
            end
        end
    end

    // ------------------------------------------------------------- sequence
    initial begin : stimulus
        model_reset();
        cur_id  = nop();
        cur_exp = '{default: 0};
        drive(nop());

        // Power-on reset; a taken branch in ID must not leak through
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(br(1, 2, 1));
        #1;
        check_all_zero("por");
        rst_n = 1'b1;
        model_reset();
        present(br(1, 2, 1));

        // ALU chain: EX forward then MEM forward
        issue(alu(1, 0, 0, 0));
        issue(alu(2, 1, 1, 1));
        issue(alu(3, 1, 0, 1));
        issue(nop()); issue(nop());
        // Load-use stall, then MEM load-data forward
        issue(ld(5, 0));
        issue(alu(6, 5, 0, 1));
        issue(nop()); issue(nop()); issue(nop());
        // Load then store data: no stall, WB->MEM fix-up two cycles later
        issue(ld(5, 0));
        issue(st(7, 5));
        issue(nop()); issue(nop()); issue(nop());
        // Load then store address: stalls
        issue(ld(5, 0));
        issue(st(5, 7));
        issue(nop()); issue(nop()); issue(nop());
        // x0 never forwards
        issue(alu(0, 0, 0, 0));
        issue(alu(3, 0, 0, 1));
        issue(nop()); issue(nop());
        // Taken branch, then taken branch behind a load-use
        issue(br(1, 2, 1));
        issue(nop());
        issue(ld(5, 0));
        issue(br(5, 1, 1));
        issue(nop()); issue(nop()); issue(nop());

        // Asynchronous reset in the middle of a stall
        issue(ld(5, 0));
        tick(alu(6, 5, 0, 1));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("rst_mid_stall");
        drive(br(5, 1, 1));
        #1;
        check("rst_flush_gated", flush_IFID, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        present(alu(6, 5, 0, 1));
        issue(br(5, 1, 1));
        issue(nop());

        // Random traffic on a small register set for frequent hazards
        repeat (4000) issue(rnd_id());

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
